// File: rtl/barrel_unrotate_seq_pkg.sv
// Shared constants for the sequential right-rotator: FSM encodings and default geometry.
// Defaults match the combinational left rotator this block undoes.
package barrel_unrotate_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/barrel_unrotate_seq_rot_down_counter.sv
// Loadable down-counter holding the remaining rotate steps; exposes zero/one flags.
// Decrement saturates at zero so a stray dec can never wrap.
module rot_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == W'(1));

endmodule

// File: rtl/barrel_unrotate_seq.sv
// Sequential right-rotator: rotates A right by S, one bit per clock, behind valid/ready on both sides.
// Build option ZERO_SKIP_EN: an S==0 word goes straight from IDLE to DONE, skipping the SHIFT cycle.
//
// state    | meaning
// ST_IDLE  | waiting for a word, in_ready high
// ST_SHIFT | rotating data right one bit per clock
// ST_DONE  | result on Y with out_valid high, held until out_ready
module barrel_unrotate_seq
  import barrel_unrotate_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] data;
  logic             accept;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             cnt_one;

  assign accept  = in_valid && (state == ST_IDLE);
  assign cnt_dec = (state == ST_SHIFT) && !cnt_zero;

  rot_down_counter #(.W(SHW)) u_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (S),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef ZERO_SKIP_EN
          state_nxt = (S == '0) ? ST_DONE : ST_SHIFT;
`else
          state_nxt = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: begin
        // count==1 is the last rotate; count==0 only happens for S==0
        if (cnt_zero || cnt_one) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (accept) begin
      data <= A;
    end else if (cnt_dec) begin
      data <= {data[0], data[WIDTH-1:1]};
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign Y         = data;

endmodule

// File: tb/tb_barrel_unrotate_seq.sv
// Scoreboard bench for barrel_unrotate_seq; expected words and latencies come from a plain arithmetic model.
// Define ZERO_SKIP_EN to match an RTL built with the zero-skip option.
module tb_barrel_unrotate_seq;

  typedef struct {
    logic [7:0] y;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [2:0] S;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Y;

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  bit   rand_rdy = 1'b0;
  bit   rdy_fix = 1'b1;
  bit   prev_ov = 1'b0;
  exp_t exp_q[$];

  barrel_unrotate_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  function automatic logic [7:0] ref_rotr(input int a, input int s);
    int r;
    r = ((a >> s) | (a << (8 - s))) & 255;
    return 8'(r);
  endfunction

  function automatic int ref_lat(input int s);
`ifdef ZERO_SKIP_EN
    return s;
`else
    return (s == 0) ? 1 : s;
`endif
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, expv, expv, cyc);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: checks every cycle a result is presented, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail("spurious_out_valid");
        end else begin
          if (!prev_ov) check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
          check("y", int'(Y), int'(exp_q[0].y));
          check("in_ready_low_in_done", int'(in_ready), 0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [7:0] a, input logic [2:0] s);
    bit   got;
    int   waited;
    exp_t e;
    got = 1'b0;
    waited = 0;
    @(negedge clk);
    A = a;
    S = s;
    in_valid = 1'b1;
    while (!got && waited < 200) begin
      got = in_ready;
      e.acc = cyc + 1;
      @(posedge clk);
      if (!got) begin
        waited++;
        @(negedge clk);
      end
    end
    if (got) begin
      e.y = ref_rotr(int'(a), int'(s));
      e.lat = ref_lat(int'(s));
      exp_q.push_back(e);
    end else begin
      fail("accept_timeout");
    end
    #1;
    in_valid = 1'b0;
    A = 8'($urandom);
    S = 3'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 2000);
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    A = 8'h00;
    S = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset / idle state
    check("rst_y", int'(Y), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Basic rotate, then in_ready one cycle after the handshake
    send(8'h4E, 3'd3);
    wait_drain();
    @(negedge clk);
    check("in_ready_after_done", int'(in_ready), 1);

    send(8'h4E, 3'd7);
    send(8'h4E, 3'd0);
    wait_drain();

    // Stalled consumer: result held, new input ignored
    rdy_fix = 1'b0;
    @(posedge clk);
    #2;
    send(8'hA5, 3'd2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail("stall_wait_out_valid");
    in_valid = 1'b1;
    A = 8'hFF;
    S = 3'd1;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_y", int'(Y), 8'h69);
    end
    in_valid = 1'b0;
    rdy_fix = 1'b1;
    wait_drain();

    // Reset in the middle of SHIFT drops the word
    send(8'hF0, 3'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_y", int'(Y), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h01, 3'd1);
    wait_drain();

    // Exhaustive sweep, back-to-back with out_ready high
    for (int a = 0; a < 256; a++) begin
      for (int s = 0; s < 8; s++) begin
        send(8'(a), 3'(s));
      end
    end
    wait_drain();

    // Random words with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 3'($urandom));
    end
    wait_drain();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
